spi_fsm: RTL and testbench
==========================

# spi_fsm

Transaction sequencer for the SPI memory slave. It watches the conditioned chip-select and SCLK edge pulses and drives the shift register's shift strobe and parallel-load input. It also strobes the address latch and data-memory write enable, and gates the MISO tri-state buffer. Each transaction is an address/RW byte followed by one data byte, either read or write.

## Interface
Parameters:
- width, 8, bits per SPI frame; equals the shift register width.

Ports:
- clk  in  1  FPGA clock; everything is on posedge.
- reset  in  1  synchronous, active-high.
- chipSelect  in  1  conditioned CS, active-low; 0 means a transaction is in progress.
- sclkPosEdge  in  1  one-clk pulse for each SCLK rising edge (conditioned).
- sclkNegEdge  in  1  one-clk pulse for each SCLK falling edge (conditioned).
- readWriteBit  in  1  shift register parallelDataOut[0]; 1 = read, 0 = write.
- shiftEnable  out  1  to the shift register's peripheralClkEdge.
- parallelLoad  out  1  to the shift register's parallelLoad; loads memory read data.
- addrLatchEnable  out  1  captures parallelDataOut[width-1:1] as the address.
- dataMemWriteEnable  out  1  writes parallelDataOut to the addressed location.
- misoEnable  out  1  enables the MISO tri-state buffer.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, GET_ADDR, LATCH_ADDR, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_RECV, WRITE_COMMIT, DONE.
- Bit counter: `$clog2(width+1)` bits. It clears on entry to GET_ADDR, READ_SHIFT and WRITE_RECV, and increments on each qualifying edge.
- IDLE:
  - chipSelect==0 → GET_ADDR.
  - Edges are ignored.
- GET_ADDR:
  - `shiftEnable = sclkPosEdge` (combinational).
  - When the width-th posedge arrives → LATCH_ADDR.
- LATCH_ADDR:
  - addrLatchEnable=1 for one cycle.
  - Then readWriteBit==1 → READ_WAIT, else → WRITE_RECV.
- READ_WAIT: one cycle for synchronous memory read latency → READ_LOAD.
- READ_LOAD: parallelLoad=1 for one cycle; misoEnable goes 1 → READ_SHIFT.
- READ_SHIFT:
  - misoEnable=1.
  - `shiftEnable = sclkNegEdge`.
  - After width negedges → DONE.
- WRITE_RECV:
  - `shiftEnable = sclkPosEdge`.
  - After width posedges → WRITE_COMMIT.
- WRITE_COMMIT: dataMemWriteEnable=1 for one cycle → DONE.
- DONE:
  - All strobes are 0 and misoEnable=0.
  - Remains here until chipSelect==1, then → IDLE.
  - Further SCLK edges are ignored.
- Abort:
  - chipSelect==1 in any non-IDLE state → IDLE next cycle. This takes priority over every other transition and edge.
  - No addrLatchEnable, dataMemWriteEnable or parallelLoad is issued in the abort cycle.
  - misoEnable drops in that same cycle.
- Edges in LATCH_ADDR, READ_WAIT, READ_LOAD and WRITE_COMMIT are ignored and not counted.
- sclkPosEdge and sclkNegEdge asserted together (protocol violation): only the edge qualifying for the current state counts.

## Timing
- Reset: state=IDLE, counter=0, every output 0.
- shiftEnable is combinational from the edge pulse and the state, so the shift happens on the same clk as the pulse.
- Strobes are registered state decodes. Each is exactly one clk wide.
- Latencies, counted from the width-th address posedge pulse cycle (N):
  - addrLatchEnable at N+1.
  - Read path: parallelLoad at N+3; misoEnable high from N+4.
  - Write path: dataMemWriteEnable one clk after the width-th data posedge.
- SCLK half-period must be at least 8 clk. This guarantees the first read negedge arrives after READ_LOAD.
- A new transaction needs chipSelect to go 1 then 0. A back-to-back transaction is legal after one clk in IDLE.

## Structure
- Shared package `spi_pkg`:
  - state enum/localparams.
  - READ_FLAG = 1.
  - default frame width 8.
- One natural sub-module: `spi_bit_counter` (clear, increment, terminal-count flag at width).
- Everything else stays in spi_fsm.

## Test plan
- Write, address 7'h2A, data 8'hC3:
  - shiftEnable pulses on exactly 16 posedges.
  - addrLatchEnable 1 clk after the 8th.
  - dataMemWriteEnable 1 clk after the 16th.
  - misoEnable stays 0 throughout.
- Read, address 7'h05:
  - addrLatchEnable at N+1, parallelLoad at N+3.
  - misoEnable high from N+4 until 1 clk after the 8th negedge.
  - shiftEnable follows negedges only.
- Abort: chipSelect→1 after 4 address posedges.
  - IDLE the next clk.
  - No addrLatchEnable or dataMemWriteEnable.
  - A following full write behaves normally.
- Abort during READ_SHIFT after 3 negedges: misoEnable drops in the same cycle; state IDLE.
- Reset asserted mid-WRITE_RECV: all outputs 0 and state IDLE at the next clk. chipSelect must then go 1 then 0 before a new transaction starts.
- Extra 4 SCLK cycles after a write, before CS rises: no further shiftEnable or strobes; busy stays 1 until CS rises.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI slave sequencer
package spi_pkg;
    localparam int FRAME_WIDTH = 8;
    localparam logic READ_FLAG = 1'b1;
    typedef enum logic [3:0] {
        IDLE, GET_ADDR, LATCH_ADDR, READ_WAIT, READ_LOAD,
        READ_SHIFT, WRITE_RECV, WRITE_COMMIT, DONE
    } state_e;
endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: counts qualifying SCLK edges and flags the edge that completes a frame
module spi_bit_counter #(
    parameter int width = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic last_o
);
    localparam int CW = $clog2(width + 1);
    logic [CW-1:0] count_q;
    always_ff @(posedge clk) begin
        if (reset || clear_i) count_q <= '0;
        else if (inc_i) count_q <= count_q + CW'(1);
    end
    // this increment brings the count to width
    assign last_o = inc_i && count_q == CW'(width - 1);
endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: sequences one address/RW byte and one data byte per SPI transaction,
// driving the shift register, address latch, memory write enable and MISO enable.
module spi_fsm
    import spi_pkg::*;
#(
    parameter int width = FRAME_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic chipSelect,
    input  logic sclkPosEdge,
    input  logic sclkNegEdge,
    input  logic readWriteBit,
    output logic shiftEnable,
    output logic parallelLoad,
    output logic addrLatchEnable,
    output logic dataMemWriteEnable,
    output logic misoEnable,
    output logic busy
);
    state_e state_q, state_d;
    logic arm_q, ale_q, pl_q, we_q, miso_q, busy_q;
    logic edge_ok, last, clear;

    assign edge_ok = !reset && !chipSelect &&
        (((state_q == GET_ADDR || state_q == WRITE_RECV) && sclkPosEdge) ||
         (state_q == READ_SHIFT && sclkNegEdge));
    assign clear = state_d != state_q && state_d inside {GET_ADDR, READ_SHIFT, WRITE_RECV};

    spi_bit_counter #(.width(width)) u_cnt (
        .clk(clk),
        .reset(reset),
        .clear_i(clear),
        .inc_i(edge_ok),
        .last_o(last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (!chipSelect && arm_q) state_d = GET_ADDR;
            GET_ADDR:     if (last) state_d = LATCH_ADDR;
            LATCH_ADDR:   state_d = (readWriteBit == READ_FLAG) ? READ_WAIT : WRITE_RECV;
            READ_WAIT:    state_d = READ_LOAD;
            READ_LOAD:    state_d = READ_SHIFT;
            READ_SHIFT:   if (last) state_d = DONE;
            WRITE_RECV:   if (last) state_d = WRITE_COMMIT;
            WRITE_COMMIT: state_d = DONE;
            default:      state_d = state_q;
        endcase
        if (chipSelect && state_q != IDLE) state_d = IDLE;
    end

    // arm_q blocks a restart after reset until chip-select has been seen high
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            arm_q   <= 1'b0;
            ale_q   <= 1'b0;
            pl_q    <= 1'b0;
            we_q    <= 1'b0;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_q | chipSelect;
            ale_q   <= state_d == LATCH_ADDR;
            pl_q    <= state_d == READ_LOAD;
            we_q    <= state_d == WRITE_COMMIT;
            miso_q  <= state_d == READ_SHIFT;
            busy_q  <= state_d != IDLE;
        end
    end

    // chip-select rising kills strobes and MISO in the abort cycle itself
    assign shiftEnable        = edge_ok;
    assign addrLatchEnable    = ale_q && !chipSelect;
    assign parallelLoad       = pl_q && !chipSelect;
    assign dataMemWriteEnable = we_q && !chipSelect;
    assign misoEnable         = miso_q && !chipSelect;
    assign busy               = busy_q;
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: table of transactions driven cycle by cycle; expected strobe events
// are queued with their cycle stamps and matched against the observed outputs.
module tb_spi_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chipSelect = 1'b1;
    logic sclkPosEdge = 1'b0;
    logic sclkNegEdge = 1'b0;
    logic readWriteBit = 1'b0;
    logic shiftEnable, parallelLoad, addrLatchEnable, dataMemWriteEnable, misoEnable, busy;

    always #5 clk = ~clk;

    spi_fsm #(.width(8)) dut (
        .clk(clk),
        .reset(reset),
        .chipSelect(chipSelect),
        .sclkPosEdge(sclkPosEdge),
        .sclkNegEdge(sclkNegEdge),
        .readWriteBit(readWriteBit),
        .shiftEnable(shiftEnable),
        .parallelLoad(parallelLoad),
        .addrLatchEnable(addrLatchEnable),
        .dataMemWriteEnable(dataMemWriteEnable),
        .misoEnable(misoEnable),
        .busy(busy)
    );

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    typedef struct {
        int rd;
        int abort_pos;
        int abort_neg;
        int use_rst;
        int extra;
        int both;
        int b2b;
        int e_shift;
        int e_ale;
        int e_pl;
        int e_we;
    } rec_t;

    ev_t exp_q[$];
    rec_t tbl[10];
    int n_checks = 0;
    int n_errors = 0;
    int cur = 0;
    int cnt[6] = '{0, 0, 0, 0, 0, 0};
    logic miso_prev = 1'b0;
    string names[6] = '{"shift", "ale", "pl", "we", "miso_rise", "miso_fall"};

    task automatic push(input int k, input int c);
        exp_q.push_back('{kind: k, cyc: c});
    endtask

    task automatic chk(input string name, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, expv, cur);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic observe(input int k, input logic act);
        if (act !== 1'b1) return;
        cnt[k]++;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL event %s: seen at cycle %0d, expected no event", names[k], cur);
        end else if (exp_q[0].kind != k || exp_q[0].cyc != cur) begin
            n_errors++;
            $display("FAIL event %s: seen at cycle %0d, expected %s at cycle %0d",
                     names[k], cur, names[exp_q[0].kind], exp_q[0].cyc);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    // one clk: drive inputs just after posedge, observe outputs at negedge
    task automatic drive(input logic cs, input logic p, input logic n, input logic rs, input logic rw);
        @(posedge clk);
        #1;
        chipSelect = cs;
        sclkPosEdge = p;
        sclkNegEdge = n;
        reset = rs;
        readWriteBit = rw;
        cur++;
        @(negedge clk);
        observe(0, shiftEnable);
        observe(1, addrLatchEnable);
        observe(2, parallelLoad);
        observe(3, dataMemWriteEnable);
        observe(4, misoEnable && !miso_prev);
        observe(5, !misoEnable && miso_prev);
        miso_prev = misoEnable;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cur) begin
            n_checks++;
            n_errors++;
            $display("FAIL event %s: missing, expected at cycle %0d, now %0d",
                     names[exp_q[0].kind], exp_q[0].cyc, cur);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic idle(input int n, input logic rw);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, rw);
    endtask

    task automatic run_txn(input int idx, input rec_t r);
        int npos, nneg, s0, a0, p0, w0;
        logic rw, q, qn, ab;
        npos = 0;
        nneg = 0;
        ab = 1'b0;
        rw = (r.rd == 0);
        s0 = cnt[0];
        a0 = cnt[1];
        p0 = cnt[2];
        w0 = cnt[3];
        drive(1'b0, 1'b0, 1'b0, 1'b0, rw);
        idle(7, rw);
        for (int k = 0; k < 16 + r.extra; k++) begin
            if (r.abort_pos > 0 && npos == r.abort_pos) begin
                ab = 1'b1;
                break;
            end
            q = npos < 8 || (r.rd == 0 && npos < 16);
            if (npos == 7) rw = (r.rd != 0);
            if (q) push(0, cur + 1);
            if (npos == 7) begin
                push(1, cur + 2);
                if (r.rd != 0) begin
                    push(2, cur + 4);
                    push(4, cur + 5);
                end
            end
            if (r.rd == 0 && npos == 15) push(3, cur + 2);
            drive(1'b0, 1'b1, q && r.both != 0, 1'b0, rw);
            npos++;
            idle(7, rw);
            if (r.abort_neg > 0 && nneg == r.abort_neg) begin
                ab = 1'b1;
                break;
            end
            qn = r.rd != 0 && npos >= 8 && nneg < 8;
            if (qn) push(0, cur + 1);
            if (qn && nneg == 7) push(5, cur + 2);
            drive(1'b0, qn && r.both != 0, 1'b1, 1'b0, rw);
            if (qn) nneg++;
            idle(7, rw);
        end
        if (ab && r.use_rst != 0) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, rw);
            chk("busy_in_reset_cycle", busy, 1'b1);
            drive(1'b0, 1'b0, 1'b0, 1'b0, rw);
            chk("busy_after_reset", busy, 1'b0);
            idle(3, rw);
            chk("no_restart_without_cs_high", busy, 1'b0);
            drive(1'b1, 1'b0, 1'b0, 1'b0, rw);
        end else if (ab) begin
            if (r.rd != 0 && npos >= 8 && nneg < 8) push(5, cur + 1);
            drive(1'b1, 1'b0, 1'b0, 1'b0, rw);
            chk("busy_in_abort_cycle", busy, 1'b1);
            drive(1'b1, 1'b0, 1'b0, 1'b0, rw);
            chk("busy_after_abort", busy, 1'b0);
        end else begin
            chk("busy_in_done", busy, 1'b1);
            drive(1'b1, 1'b0, 1'b0, 1'b0, rw);
            chk("busy_cs_rise_cycle", busy, 1'b1);
            drive(r.b2b != 0 ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, rw);
            chk("busy_idle_after_done", busy, 1'b0);
            if (r.b2b != 0) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, rw);
                chk("busy_back_to_back_start", busy, 1'b1);
            end
        end
        chk_int($sformatf("rec%0d_pending_events", idx), exp_q.size(), 0);
        chk_int($sformatf("rec%0d_shift_count", idx), cnt[0] - s0, r.e_shift);
        chk_int($sformatf("rec%0d_ale_count", idx), cnt[1] - a0, r.e_ale);
        chk_int($sformatf("rec%0d_pl_count", idx), cnt[2] - p0, r.e_pl);
        chk_int($sformatf("rec%0d_we_count", idx), cnt[3] - w0, r.e_we);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //          rd apos aneg rst ext both b2b shift ale pl we
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 16, 1, 0, 1};  // write 2A <- C3
        tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 16, 1, 1, 0};  // read 05
        tbl[2] = '{0, 4, 0, 0, 0, 0, 0, 4, 0, 0, 0};   // abort in address phase
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 16, 1, 0, 1};  // normal write after abort
        tbl[4] = '{1, 0, 3, 0, 0, 0, 0, 11, 1, 1, 0};  // abort after 3 read negedges
        tbl[5] = '{0, 12, 0, 1, 0, 0, 0, 12, 1, 0, 0}; // reset mid data receive
        tbl[6] = '{0, 0, 0, 0, 4, 0, 0, 16, 1, 0, 1};  // extra SCLK after write
        tbl[7] = '{0, 0, 0, 0, 0, 1, 1, 16, 1, 0, 1};  // both edges, back-to-back
        tbl[8] = '{1, 0, 0, 0, 0, 1, 0, 16, 1, 1, 0};  // read with both edges
        tbl[9] = '{1, 0, 0, 0, 2, 0, 0, 16, 1, 1, 0};  // extra SCLK after read
        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("reset_shiftEnable", shiftEnable, 1'b0);
        chk("reset_parallelLoad", parallelLoad, 1'b0);
        chk("reset_addrLatchEnable", addrLatchEnable, 1'b0);
        chk("reset_dataMemWriteEnable", dataMemWriteEnable, 1'b0);
        chk("reset_misoEnable", misoEnable, 1'b0);
        chk("reset_busy", busy, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("idle_with_cs_high", busy, 1'b0);
        for (int i = 0; i < 10; i++) run_txn(i, tbl[i]);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
